// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; without it, divide codes return 0 one cycle after accept.
module muldiv_unit #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      alu_ctrl_i,
    input  logic [BITS-1:0] src_a_i,
    input  logic [BITS-1:0] src_b_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [BITS-1:0] result_o
);
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
    localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
    localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
    localparam logic [4:0] ALUCTRL_REM    = 5'h16;
    localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]   cnt_q;
    logic [4:0]      op_q;
    logic [BITS-1:0] hi_q, lo_q, opnd_q, result_q;
    logic            neg_q;

    function automatic logic [BITS-1:0] cneg(input logic n, input logic [BITS-1:0] v);
        return n ? -v : v;
    endfunction

    logic            is_mul, is_div, is_m, a_signed, b_signed, sa, sb, accept, fast;
    logic [BITS-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        is_mul   = alu_ctrl_i inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU};
        is_div   = alu_ctrl_i inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
        is_m     = is_mul | is_div;
        a_signed = alu_ctrl_i inside {ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM};
        b_signed = alu_ctrl_i inside {ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM};
        sa       = a_signed & src_a_i[BITS-1];
        sb       = b_signed & src_b_i[BITS-1];
        a_mag    = cneg(sa, src_a_i);
        b_mag    = cneg(sb, src_b_i);
        accept   = valid_i & (state_q == IDLE) & ~kill_i & is_m;
`ifdef MULDIV_DIV_EN
        fast     = 1'b0;
        fast_res = '0;
        if (is_div && src_b_i == '0) begin
            fast     = 1'b1;
            fast_res = (alu_ctrl_i inside {ALUCTRL_DIV, ALUCTRL_DIVU}) ? '1 : src_a_i;
        end else if (is_div && a_signed && src_a_i == {1'b1, {(BITS-1){1'b0}}} && src_b_i == '1) begin
            // Most-negative / -1 overflows; answer is fixed, no iteration needed
            fast     = 1'b1;
            fast_res = (alu_ctrl_i == ALUCTRL_DIV) ? src_a_i : '0;
        end
`else
        fast     = is_div;
        fast_res = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : CALC;
            CALC:    if (cnt_q == CW'(BITS-1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    // One iteration: {hi,lo} holds partial product (multiplier shifting out of lo)
    // or partial remainder / quotient (dividend shifting out of lo, quotient in).
    logic [BITS:0]   mul_sum;
    logic [BITS-1:0] step_hi, step_lo;
`ifdef MULDIV_DIV_EN
    logic [BITS:0]   div_shift, div_diff;
    logic            rneg_q;
`endif

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        step_hi = mul_sum[BITS:1];
        step_lo = {mul_sum[0], lo_q[BITS-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[BITS-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU}) begin
            step_hi = div_diff[BITS] ? div_shift[BITS-1:0] : div_diff[BITS-1:0];
            step_lo = {lo_q[BITS-2:0], ~div_diff[BITS]};
        end
`endif
    end

    logic signed [2*BITS-1:0] prod, prod_fix;
    logic [BITS-1:0]          fix_res;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        fix_res  = (op_q == ALUCTRL_MUL) ? prod_fix[BITS-1:0] : prod_fix[2*BITS-1:BITS];
`ifdef MULDIV_DIV_EN
        if (op_q inside {ALUCTRL_DIV, ALUCTRL_DIVU}) fix_res = cneg(neg_q, lo_q);
        if (op_q inside {ALUCTRL_REM, ALUCTRL_REMU}) fix_res = cneg(rneg_q, hi_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)                cnt_q <= '0;
            else if (state_q == CALC)  cnt_q <= cnt_q + CW'(1);
            if (accept && fast)                result_q <= fast_res;
            else if (state_q == FIX && !kill_i) result_q <= fix_res;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= alu_ctrl_i;
            opnd_q <= is_div ? b_mag : a_mag;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            neg_q  <= sa ^ sb;
`ifdef MULDIV_DIV_EN
            rneg_q <= sa;
`endif
        end else if (state_q == CALC) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter BITS, default 32, datapath width in bits and iteration count.
REQ-002 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port valid_i, input, 1 bit, operation request.
REQ-005 SHALL have port alu_ctrl_i, input, 5 bits, ALUCTRL_* code from alu_control_def.v.
REQ-006 SHALL have port src_a_i, input, BITS, rs1 operand (multiplicand or dividend).
REQ-007 SHALL have port src_b_i, input, BITS, rs2 operand (multiplier or divisor).
REQ-008 SHALL have port kill_i, input, 1 bit, pipeline flush; aborts the current operation.
REQ-009 SHALL have port ready_o, output, 1 bit, high only in IDLE.
REQ-010 SHALL have port done_o, output, 1 bit, single-cycle result-valid pulse.
REQ-011 SHALL have port result_o, output, BITS, result; held until the next accept.

Function
REQ-012 SHALL accept the M-extension codes: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-013 SHALL accept an operation on a rising edge when valid_i=1, ready_o=1, kill_i=0 and alu_ctrl_i is an M-extension code, and SHALL latch operands and code on that edge.
REQ-014 SHALL ignore valid_i with a non-M code (state unchanged, done_o stays 0), and SHALL ignore valid_i while ready_o=0.
REQ-015 SHALL implement states IDLE, CALC, FIX and DONE, with transitions IDLE->CALC on accept, CALC->FIX after BITS iterations, FIX->DONE and DONE->IDLE unconditionally.
REQ-016 SHALL keep an iteration counter of width clog2(BITS), cleared on accept, incremented each CALC cycle, and SHALL leave CALC when the counter equals BITS-1.
REQ-017 SHALL multiply by radix-2 shift-add on operand magnitudes into a 2*BITS product; MUL returns the low half, and MULH, MULHSU and MULHU return the high half.
REQ-018 SHALL treat signedness as: MULH both operands signed; MULHSU src_a signed, src_b unsigned; MULHU, DIVU and REMU unsigned; DIV and REM signed.
REQ-019 SHALL divide by restoring division on magnitudes, one quotient bit per CALC cycle.
REQ-020 SHALL in FIX apply two's-complement negation: product negated when operand signs differ (signed operands only); quotient negated when signs differ; remainder takes the dividend's sign.
REQ-021 SHALL drive done_o=1 and update result_o in DONE only, which is BITS+2 cycles after the accepting edge (34 for BITS=32).
REQ-022 SHALL handle divide by zero as IDLE->DONE directly (done_o one cycle after accept): DIV and DIVU return all-ones; REM and REMU return src_a.
REQ-023 SHALL handle signed overflow (DIV or REM of 0x80000000 by 0xFFFFFFFF) as IDLE->DONE directly: DIV returns 0x80000000 and REM returns 0.
REQ-024 SHALL on kill_i=1 in any state go to IDLE on that edge, with done_o=0 in the following cycle and result_o unchanged; kill_i overrides DONE and accept.

Reset
REQ-025 SHALL on rst=1 go to IDLE and clear the counter, with result_o=0, done_o=0 and ready_o=1 in the following cycle.
REQ-026 SHALL give rst priority over kill_i and valid_i, including mid-CALC, where it discards the partial result.

Configuration
REQ-027 SHALL include the divider datapath and behave per REQ-019..REQ-023 when macro MULDIV_DIV_EN is defined.
REQ-028 SHALL omit the divider when MULDIV_DIV_EN is undefined: DIV, DIVU, REM and REMU are accepted, go IDLE->DONE, and return 0 one cycle after accept, while multiply behaviour is unchanged.

Verification
REQ-029 SHALL cover MUL src_a=7, src_b=0xFFFFFFFD -> result_o=0xFFFFFFEB, done_o high for one cycle exactly 34 cycles after accept, ready_o low in between.
REQ-030 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 SHALL cover DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 SHALL cover DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each with done_o one cycle after accept.
REQ-033 SHALL cover kill_i in the 10th CALC cycle of a MUL -> no done_o, ready_o=1 next cycle, and a following MUL 3x4 -> 12; the same sequence with rst instead -> result_o=0 before the new operation.
REQ-034 SHALL cover, with MULDIV_DIV_EN undefined, DIVU 100/7 -> result_o=0 with done_o one cycle after accept, and MUL 7x3 -> 21 after 34 cycles.
